// File: rtl/huffman_pkg.sv
// Shared types and helpers for the Huffman decoder datapath.
package huffman_pkg;

    localparam int unsigned NSYM   = 6;
    localparam int unsigned CODE_W = 8;

    typedef logic [2:0]        sym_t;
    typedef logic [CODE_W-1:0] code_t;
    typedef logic [3:0]        len_t;

    typedef enum logic [1:0] {
        EMPTY,
        RUN,
        ERR
    } dec_state_t;

    function automatic len_t code_len(code_t m);
        len_t n;
        n = '0;
        for (int unsigned i = 0; i < CODE_W; i++) begin
            n = n + len_t'(m[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/huffman_decoder_if.sv
// Table/bitstream/symbol bus of the Huffman decoder.
// CNT1..CNT6 exist only when HUFF_DEC_CNT_EN is defined.
interface huffman_decoder_if;
    import huffman_pkg::*;

    logic  table_valid;
    code_t HC1, HC2, HC3, HC4, HC5, HC6;
    code_t M1, M2, M3, M4, M5, M6;
    logic  bit_valid;
    logic  bit_in;
    logic  sym_valid;
    sym_t  sym;
    logic  partial;
    logic  err;
`ifdef HUFF_DEC_CNT_EN
    logic [7:0] CNT1, CNT2, CNT3, CNT4, CNT5, CNT6;
`endif

`ifdef HUFF_DEC_CNT_EN
    modport master (
        output table_valid, HC1, HC2, HC3, HC4, HC5, HC6,
               M1, M2, M3, M4, M5, M6, bit_valid, bit_in,
        input  sym_valid, sym, partial, err,
               CNT1, CNT2, CNT3, CNT4, CNT5, CNT6
    );
    modport slave (
        input  table_valid, HC1, HC2, HC3, HC4, HC5, HC6,
               M1, M2, M3, M4, M5, M6, bit_valid, bit_in,
        output sym_valid, sym, partial, err,
               CNT1, CNT2, CNT3, CNT4, CNT5, CNT6
    );
`else
    modport master (
        output table_valid, HC1, HC2, HC3, HC4, HC5, HC6,
               M1, M2, M3, M4, M5, M6, bit_valid, bit_in,
        input  sym_valid, sym, partial, err
    );
    modport slave (
        input  table_valid, HC1, HC2, HC3, HC4, HC5, HC6,
               M1, M2, M3, M4, M5, M6, bit_valid, bit_in,
        output sym_valid, sym, partial, err
    );
`endif

endinterface

// File: rtl/huffman_code_match.sv
// Combinational match of the next shift-register state against one table entry.
module huffman_code_match
    import huffman_pkg::*;
(
    input  code_t i_sr_n,
    input  len_t  i_k_n,
    input  code_t i_hc,
    input  code_t i_m,
    input  len_t  i_len,
    output logic  o_match
);

    // A zero-length entry (mask 0) is unloaded and must never match.
    assign o_match = (i_len != '0) && (i_len == i_k_n) && ((i_sr_n & i_m) == i_hc);

endmodule

// File: rtl/huffman_decoder.sv
// Serial Huffman decoder: one code bit per cycle in, symbol index 1..6 out.
// Optional per-symbol decode counters are enabled by defining HUFF_DEC_CNT_EN.
module huffman_decoder
    import huffman_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    huffman_decoder_if.slave bus
);

    code_t      r_hc  [NSYM];
    code_t      r_m   [NSYM];
    len_t       r_len [NSYM];
    code_t      r_sr;
    len_t       r_k;
    dec_state_t r_state;
    logic       r_sym_valid;
    sym_t       r_sym;

    code_t      w_hc_in [NSYM];
    code_t      w_m_in  [NSYM];
    code_t      w_sr_sh;
    len_t       w_k_inc;
    logic [NSYM-1:0] w_match;
    logic       w_any;
    sym_t       w_sel;

    dec_state_t w_state_n;
    code_t      w_sr_n;
    len_t       w_k_n;
    logic       w_sym_valid_n;
    sym_t       w_sym_n;

    assign w_hc_in[0] = bus.HC1;
    assign w_hc_in[1] = bus.HC2;
    assign w_hc_in[2] = bus.HC3;
    assign w_hc_in[3] = bus.HC4;
    assign w_hc_in[4] = bus.HC5;
    assign w_hc_in[5] = bus.HC6;
    assign w_m_in[0]  = bus.M1;
    assign w_m_in[1]  = bus.M2;
    assign w_m_in[2]  = bus.M3;
    assign w_m_in[3]  = bus.M4;
    assign w_m_in[4]  = bus.M5;
    assign w_m_in[5]  = bus.M6;

    assign w_sr_sh = {r_sr[CODE_W-2:0], bus.bit_in};
    assign w_k_inc = len_t'(r_k + len_t'(1));

    for (genvar g = 0; g < NSYM; g++) begin : g_match
        huffman_code_match u_match (
            .i_sr_n  (w_sr_sh),
            .i_k_n   (w_k_inc),
            .i_hc    (r_hc[g]),
            .i_m     (r_m[g]),
            .i_len   (r_len[g]),
            .o_match (w_match[g])
        );
    end

    // Lowest index wins if a non-prefix-free table produces several matches.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int unsigned i = 0; i < NSYM; i++) begin
            if (w_match[i] && !w_any) begin
                w_any = 1'b1;
                w_sel = sym_t'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NSYM; i++) begin
                r_hc[i]  <= '0;
                r_m[i]   <= '0;
                r_len[i] <= '0;
            end
        end else if (bus.table_valid) begin
            for (int unsigned i = 0; i < NSYM; i++) begin
                r_hc[i]  <= w_hc_in[i] & w_m_in[i];
                r_m[i]   <= w_m_in[i];
                r_len[i] <= code_len(w_m_in[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_sr        <= '0;
            r_k         <= '0;
            r_sym_valid <= 1'b0;
            r_sym       <= '0;
        end else begin
            r_state     <= w_state_n;
            r_sr        <= w_sr_n;
            r_k         <= w_k_n;
            r_sym_valid <= w_sym_valid_n;
            r_sym       <= w_sym_n;
        end
    end

    // A table strobe overrides everything, including a coincident bit.
    always_comb begin
        w_state_n     = r_state;
        w_sr_n        = r_sr;
        w_k_n         = r_k;
        w_sym_valid_n = 1'b0;
        w_sym_n       = r_sym;
        if (bus.table_valid) begin
            w_state_n = RUN;
            w_sr_n    = '0;
            w_k_n     = '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (bus.bit_valid) begin
                        if (w_any) begin
                            w_sym_valid_n = 1'b1;
                            w_sym_n       = w_sel;
                            w_sr_n        = '0;
                            w_k_n         = '0;
                        end else if (w_k_inc == len_t'(CODE_W)) begin
                            w_state_n = ERR;
                            w_sr_n    = '0;
                            w_k_n     = '0;
                        end else begin
                            w_sr_n = w_sr_sh;
                            w_k_n  = w_k_inc;
                        end
                    end
                end
                EMPTY, ERR: begin
                    w_state_n = r_state;
                end
                default: begin
                    w_state_n = EMPTY;
                end
            endcase
        end
    end

    assign bus.sym_valid = r_sym_valid;
    assign bus.sym       = r_sym;
    assign bus.partial   = (r_k != '0);
    assign bus.err       = (r_state == ERR);

`ifdef HUFF_DEC_CNT_EN
    logic [7:0] r_cnt [NSYM];

    always_ff @(posedge clk) begin
        if (!rst_n || bus.table_valid) begin
            for (int unsigned i = 0; i < NSYM; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NSYM; i++) begin
                if (w_sym_valid_n && (w_sym_n == sym_t'(i + 1)) && (r_cnt[i] != '1)) begin
                    r_cnt[i] <= r_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign bus.CNT1 = r_cnt[0];
    assign bus.CNT2 = r_cnt[1];
    assign bus.CNT3 = r_cnt[2];
    assign bus.CNT4 = r_cnt[3];
    assign bus.CNT5 = r_cnt[4];
    assign bus.CNT6 = r_cnt[5];
`endif

endmodule
